// File: rtl/enigma_pkg.sv
// Constants and state encoding shared by the rotor and reflector stages.
package enigma_pkg;
   localparam int N_LETTERS = 26;
   localparam int BASE      = 65;
   localparam int MAP_W     = 8 * N_LETTERS;
   localparam int CNT_W     = 5;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READY,
      LOOKUP,
      DONE
   } state_t;
endpackage

// File: rtl/map_lookup.sv
// Combinational extraction of byte idx from a packed letter table; entry 0 sits in the MSBs.
module map_lookup #(
   parameter int N_LETTERS = 26,
   parameter int MAP_W     = 208
)(
   input  logic [MAP_W-1:0] map_bits,
   input  logic [7:0]       idx,
   output logic [7:0]       entry,
   output logic             hit
);
   logic [7:0] slice [N_LETTERS];

   generate
      for (genvar gi = 0; gi < N_LETTERS; gi++) begin : g_slice
         assign slice[gi] = map_bits[MAP_W-1-8*gi -: 8];
      end
   endgenerate

   assign hit = (idx < 8'(N_LETTERS));

   always_comb begin
      entry = 8'h00;
      for (int i = 0; i < N_LETTERS; i++) begin
         if (idx == 8'(i)) entry = slice[i];
      end
   end
endmodule

// File: rtl/reflector.sv
// Enigma reflector: validates a loaded involution table, then reflects one letter per 3 cycles.
module reflector #(
   parameter int N_LETTERS = enigma_pkg::N_LETTERS,
   parameter int BASE      = enigma_pkg::BASE
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       set,
   input  logic [enigma_pkg::MAP_W-1:0] map_in,
   input  logic                       valid,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout,
   output logic                       done,
   output logic                       busy,
   output logic                       cfg_ok,
   output logic                       err
);
   import enigma_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_LETTERS - 1);

   state_t           state_reg;
   logic [MAP_W-1:0] table_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [7:0]       din_reg;
   logic [7:0]       idx_reg;
   logic             fail_reg;

   logic [7:0] sel_idx;
   logic [7:0] entry_a;
   logic [7:0] entry_b;
   logic [7:0] off_a;
   logic [7:0] cnt_ext;
   logic       hit_a;
   logic       hit_b;
   logic       entry_fail;

   // The forward lookup serves the scan in CHECK and the reflection in DONE.
   assign cnt_ext = {{(8-CNT_W){1'b0}}, cnt_reg};
   assign sel_idx = (state_reg == CHECK) ? cnt_ext : idx_reg;

   map_lookup #(.N_LETTERS(N_LETTERS), .MAP_W(MAP_W)) u_fwd (
      .map_bits (table_reg),
      .idx      (sel_idx),
      .entry    (entry_a),
      .hit      (hit_a)
   );

   assign off_a = entry_a - 8'(BASE);

   map_lookup #(.N_LETTERS(N_LETTERS), .MAP_W(MAP_W)) u_inv (
      .map_bits (table_reg),
      .idx      (off_a),
      .entry    (entry_b),
      .hit      (hit_b)
   );

   // Out-of-range, fixed point, or the image does not map back to k.
   assign entry_fail = !hit_b || (off_a == cnt_ext) || (entry_b != (8'(BASE) + cnt_ext));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         table_reg <= '0;
         cnt_reg   <= '0;
         din_reg   <= 8'h00;
         idx_reg   <= 8'h00;
         fail_reg  <= 1'b0;
         dout      <= 8'h00;
         done      <= 1'b0;
         busy      <= 1'b1;
         cfg_ok    <= 1'b0;
         err       <= 1'b0;
      end else if (set) begin
         table_reg <= map_in;
         cnt_reg   <= '0;
         fail_reg  <= 1'b0;
         cfg_ok    <= 1'b0;
         err       <= 1'b0;
         dout      <= 8'h00;
         done      <= 1'b0;
         busy      <= 1'b1;
         state_reg <= CHECK;
      end else begin
         done <= 1'b0;
         dout <= 8'h00;
         case (state_reg)
            CHECK: begin
               fail_reg <= fail_reg | entry_fail;
               if (cnt_reg == LAST) begin
                  if (fail_reg || entry_fail) begin
                     err       <= 1'b1;
                     cfg_ok    <= 1'b0;
                     busy      <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     cfg_ok    <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= READY;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            READY: begin
               if (valid) begin
                  din_reg   <= din;
                  busy      <= 1'b1;
                  state_reg <= LOOKUP;
               end
            end
            LOOKUP: begin
               idx_reg   <= din_reg - 8'(BASE);
               state_reg <= DONE;
            end
            DONE: begin
               done      <= 1'b1;
               dout      <= hit_a ? entry_a : din_reg;
               if (!hit_a) err <= 1'b1;
               busy      <= 1'b0;
               state_reg <= READY;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_reflector.sv
// Self-checking bench for reflector: constant vectors, corner sequences and a random model comparison.
module tb_reflector;
   localparam logic [207:0] REF_MAP = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         set = 1'b0;
   logic [207:0] map_in = '0;
   logic         valid = 1'b0;
   logic [7:0]   din = 8'h00;
   logic [7:0]   dout;
   logic         done;
   logic         busy;
   logic         cfg_ok;
   logic         err;

   int checks = 0;
   int errors = 0;

   logic [207:0] cur_map;
   bit           model_err;

   typedef struct {
      logic [7:0] din;
      logic [7:0] dout;
      logic       err;
   } vec_t;

   vec_t vt [5];

   always #5 clk = ~clk;

   reflector dut (
      .clk    (clk),
      .reset  (reset),
      .set    (set),
      .map_in (map_in),
      .valid  (valid),
      .din    (din),
      .dout   (dout),
      .done   (done),
      .busy   (busy),
      .cfg_ok (cfg_ok),
      .err    (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [207:0] m, input int k);
      return m[207-8*k -: 8];
   endfunction

   // Table is usable iff every letter maps to a different letter that maps straight back.
   function automatic bit model_ok(input logic [207:0] m);
      int e [26];
      for (int k = 0; k < 26; k++) e[k] = int'(byte_of(m, k));
      for (int k = 0; k < 26; k++) begin
         if (e[k] < 65 || e[k] > 90) return 1'b0;
         if (e[k] == 65 + k) return 1'b0;
         if (e[e[k]-65] != 65 + k) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [207:0] random_involution();
      int p [26];
      int j, t;
      logic [207:0] m;
      for (int i = 0; i < 26; i++) p[i] = i;
      for (int i = 25; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = p[i]; p[i] = p[j]; p[j] = t;
      end
      m = '0;
      for (int i = 0; i < 13; i++) begin
         m[207-8*p[2*i]   -: 8] = 8'(65 + p[2*i+1]);
         m[207-8*p[2*i+1] -: 8] = 8'(65 + p[2*i]);
      end
      return m;
   endfunction

   task automatic load(input logic [207:0] m, output int cyc);
      map_in = m;
      set = 1'b1;
      @(negedge clk);
      set = 1'b0;
      cyc = 0;
      while (!cfg_ok && !err && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      cur_map = m;
      model_err = !model_ok(m);
      $display("load cfg_ok=%b err=%b busy=%b cycles=%0d", cfg_ok, err, busy, cyc);
   endtask

   task automatic load_check(input logic [207:0] m, input string tag);
      int cyc;
      bit ok;
      ok = model_ok(m);
      load(m, cyc);
      chk({tag, " cycles"}, 32'(cyc), 32'd26);
      chk({tag, " cfg_ok"}, 32'(cfg_ok), 32'(ok));
      chk({tag, " err"}, 32'(err), 32'(!ok));
      chk({tag, " busy"}, 32'(busy), 32'(!ok));
   endtask

   // Returns at the negedge where done is seen (lat=3 expected) or lat=10 on timeout.
   task automatic send(input logic [7:0] d, output int lat, output logic [7:0] got, output logic got_err);
      valid = 1'b1;
      din = d;
      @(negedge clk);
      valid = 1'b0;
      din = 8'h00;
      lat = 1;
      while (!done && lat < 10) begin
         chk("dout idle zero", 32'(dout), 32'd0);
         @(negedge clk);
         lat++;
      end
      got = dout;
      got_err = err;
      $display("letter din=%h dout=%h done=%b err=%b lat=%0d", d, got, done, got_err, lat);
   endtask

   task automatic model_letter(input logic [7:0] d);
      int lat;
      logic [7:0] got, exp;
      logic ge;
      int idx;
      idx = int'(d) - 65;
      if (idx >= 0 && idx < 26) exp = byte_of(cur_map, idx);
      else begin
         exp = d;
         model_err = 1'b1;
      end
      send(d, lat, got, ge);
      chk("rand latency", 32'(lat), 32'd3);
      chk("rand dout", 32'(got), 32'(exp));
      chk("rand err", 32'(ge), 32'(model_err));
   endtask

   initial begin
      int lat, cyc, nd;
      logic [7:0] got;
      logic ge;
      logic [207:0] m;

      vt[0] = '{din: 8'h41, dout: 8'h59, err: 1'b0};
      vt[1] = '{din: 8'h59, dout: 8'h41, err: 1'b0};
      vt[2] = '{din: 8'h5A, dout: 8'h54, err: 1'b0};
      vt[3] = '{din: 8'h31, dout: 8'h31, err: 1'b1};
      vt[4] = '{din: 8'h40, dout: 8'h40, err: 1'b1};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset dout", 32'(dout), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset busy", 32'(busy), 32'd1);
      chk("reset cfg_ok", 32'(cfg_ok), 32'd0);
      chk("reset err", 32'(err), 32'd0);

      // Valid reference table, then the constant vectors.
      load_check(REF_MAP, "ref load");
      for (int i = 0; i < 5; i++) begin
         send(vt[i].din, lat, got, ge);
         chk("vec latency", 32'(lat), 32'd3);
         chk("vec dout", 32'(got), 32'(vt[i].dout));
         chk("vec err", 32'(ge), 32'(vt[i].err));
      end
      @(negedge clk);
      chk("done one cycle", 32'(done), 32'd0);
      chk("dout after done", 32'(dout), 32'd0);

      // Valid during LOOKUP is ignored.
      load_check(REF_MAP, "reload");
      valid = 1'b1; din = 8'h42;
      @(negedge clk);
      din = 8'h43;
      @(negedge clk);
      valid = 1'b0; din = 8'h00;
      @(negedge clk);
      chk("lookup-valid done", 32'(done), 32'd1);
      chk("lookup-valid dout", 32'(dout), 32'h52);
      nd = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("lookup-valid extra done", 32'(nd), 32'd0);

      // Set and valid together in READY: reconfiguration wins, no done.
      map_in = REF_MAP; set = 1'b1; valid = 1'b1; din = 8'h41;
      @(negedge clk);
      set = 1'b0; valid = 1'b0; din = 8'h00;
      chk("set+valid busy", 32'(busy), 32'd1);
      chk("set+valid cfg_ok", 32'(cfg_ok), 32'd0);
      nd = 0; cyc = 0;
      while (!cfg_ok && !err && cyc < 60) begin
         @(negedge clk);
         if (done) nd++;
         cyc++;
      end
      chk("set+valid no done", 32'(nd), 32'd0);
      chk("set+valid cycles", 32'(cyc), 32'd26);
      chk("set+valid cfg_ok end", 32'(cfg_ok), 32'd1);

      // Reset while in LOOKUP aborts with no done.
      valid = 1'b1; din = 8'h41;
      @(negedge clk);
      valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst-lookup done", 32'(done), 32'd0);
      chk("rst-lookup dout", 32'(dout), 32'd0);
      chk("rst-lookup busy", 32'(busy), 32'd1);
      chk("rst-lookup cfg_ok", 32'(cfg_ok), 32'd0);
      chk("rst-lookup err", 32'(err), 32'd0);
      nd = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("rst-lookup no done", 32'(nd), 32'd0);

      // Fixed point at entry 0.
      m = REF_MAP;
      m[207:200] = 8'h41;
      load_check(m, "fixed");
      send(8'h42, lat, got, ge);
      chk("fixed no done", 32'(lat), 32'd10);

      // Random tables (some corrupted) and random letters against the model.
      for (int r = 0; r < 8; r++) begin
         m = random_involution();
         if ($urandom_range(0, 2) == 0) m[207-8*int'($urandom_range(0, 25)) -: 8] = 8'($urandom_range(0, 255));
         load_check(m, "rand load");
         if (model_ok(m)) begin
            for (int i = 0; i < 15; i++) begin
               if ($urandom_range(0, 4) == 0) model_letter(8'($urandom_range(0, 255)));
               else model_letter(8'(65 + $urandom_range(0, 25)));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reflector.md
REFLECTOR -- requirements
Module: reflector

Interface
REQ-001 SHALL have parameter N_LETTERS, default 26, alphabet size.
REQ-002 SHALL have parameter BASE, default 65, ASCII code of 'A'.
REQ-003 SHALL have port clk  in  1  the single clock; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port set  in  1  load-configuration strobe.
REQ-006 SHALL have port map_in  in  208  reflection table; entry k occupies bits [207-8k -: 8] and is the ASCII image of letter BASE+k.
REQ-007 SHALL have port valid  in  1  one-cycle input strobe from the upstream rotor's done.
REQ-008 SHALL have port din  in  8  ASCII letter from the upstream rotor's dout.
REQ-009 SHALL have port dout  out  8  reflected ASCII letter, fed to the return-path rotor.
REQ-010 SHALL have port done  out  1  one-cycle result strobe.
REQ-011 SHALL have port busy  out  1  high in every state except READY.
REQ-012 SHALL have port cfg_ok  out  1  table validated and usable.
REQ-013 SHALL have port err  out  1  sticky error: table invalid, or an input was rejected.

Function
REQ-014 SHALL implement states IDLE, CHECK, READY, LOOKUP, DONE.
- IDLE -> CHECK on set.
- CHECK -> READY or IDLE after the scan.
- READY -> LOOKUP on valid.
- LOOKUP -> DONE.
- DONE -> READY.
REQ-015 SHALL, on set in any state, register map_in, clear cfg_ok and err, zero the scan counter and enter CHECK; set takes priority over valid in the same cycle.
REQ-016 SHALL, in CHECK, examine exactly one entry k per cycle for k = 0..25, using a 5-bit counter.
REQ-017 SHALL fail entry k if any of these holds:
- entry k lies outside BASE..BASE+25;
- entry k equals BASE+k (fixed point);
- entry (entry k - BASE) does not equal BASE+k (not an involution).
REQ-018 SHALL, after entry 25 is examined (26 CHECK cycles), go to READY with cfg_ok=1 if no entry failed; otherwise go to IDLE with err=1 and cfg_ok=0.
REQ-019 SHALL ignore valid in every state except READY; a pulse that is ignored for this reason does not set err.
REQ-020 SHALL, on valid in READY, latch din and enter LOOKUP.
REQ-021 SHALL compute the index in LOOKUP as din - BASE with 8-bit unsigned arithmetic; an index of 26 or more (din outside 'A'..'Z') is invalid.
REQ-022 SHALL assert done=1 for exactly one cycle in DONE.
- Valid index: dout = table entry (din - BASE).
- Invalid index: dout = din unchanged, and err is set.
- Latency: valid sampled at edge t gives done=1 during the cycle after edge t+2.
REQ-023 SHALL drive dout = 8'h00 whenever done = 0.
REQ-024 SHALL hold err until the next set or reset.
REQ-025 SHALL accept back-to-back letters: the next valid is accepted on the cycle after DONE, giving a throughput of one letter per 3 cycles.

Reset
REQ-026 SHALL, on reset at any clock edge, set state=IDLE, table=0, counter=0, latched din=0, dout=0, done=0, busy=1, cfg_ok=0, err=0.
REQ-027 SHALL let reset mid-CHECK or mid-LOOKUP abort the operation with no done pulse; set and valid in the same cycle as reset are ignored.

Structure
REQ-028 SHALL take N_LETTERS, BASE, MAP_W (208) and the state encoding from the shared package enigma_pkg, which the rotor stage also uses.
REQ-029 SHALL instantiate one sub-module, map_lookup: combinational extraction of byte k from the 208-bit table, shared by CHECK and LOOKUP.
REQ-030 SHALL keep every register in a single synchronous-reset clocked process.

Verification
All scenarios use map "YRUHQSLDPXNGOKMIEBFZCWVJAT" unless stated otherwise.
REQ-031 SHALL cover the valid table: set=1 for one cycle -> busy for 26 cycles, then cfg_ok=1, err=0, busy=0.
REQ-032 SHALL cover reflection: valid with din=8'h41 ('A') -> done one cycle later than LOOKUP with dout=8'h59 ('Y'); din=8'h59 -> dout=8'h41.
REQ-033 SHALL cover a fixed point: map with entry 0 = 'A' -> after 26 CHECK cycles, state IDLE, err=1, cfg_ok=0, and a following valid produces no done.
REQ-034 SHALL cover the boundaries:
- din=8'h5A ('Z') -> dout=8'h54 ('T');
- din=8'h31 -> done with dout=8'h31 and err=1;
- din=8'h40 -> same pass-through behaviour.
REQ-035 SHALL cover simultaneous events: valid during LOOKUP is ignored; set and valid in the same READY cycle -> CHECK entered and no done; reset asserted in LOOKUP -> no done and all outputs at their reset values on the next cycle.
